// File: rtl/systolic_ctrl.sv
// Sequencer for the 8x8 systolic MVM array: SRAM read addressing, array advance and result-row flags.
// Optional SYSTOLIC_CTRL_PERF_EN adds a saturating stall counter port perf_stall_cnt.
module systolic_ctrl #(
    parameter int ARRAY_SIZE    = 8,
    parameter int K_ACCUM_DEPTH = 8,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start,
    input  logic [5:0]            num_sets,
    input  logic                  abort,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_raddr_w,
    output logic [ADDR_WIDTH-1:0] sram_raddr_d,
    output logic                  alu_start,
    output logic [8:0]            cycle_num,
    output logic [5:0]            data_set,
    output logic [5:0]            matrix_index,
    output logic                  out_valid
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [15:0]           perf_stall_cnt
`endif
);

    localparam int RUN_LEN = K_ACCUM_DEPTH + ARRAY_SIZE + 1;
    localparam int KW      = $clog2(K_ACCUM_DEPTH + 1);

    localparam logic [KW-1:0]         K_MAX     = KW'(K_ACCUM_DEPTH);
    localparam logic [KW-1:0]         K_ONE     = KW'(1);
    localparam logic [8:0]            CYC_LAST  = 9'(RUN_LEN - 1);
    localparam logic [8:0]            CYC_VALID = 9'(K_ACCUM_DEPTH);
    localparam logic [8:0]            ROW0      = 9'(K_ACCUM_DEPTH + 1);
    localparam logic [8:0]            ROWS      = 9'(ARRAY_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [5:0]              set_q, set_d;
    logic [5:0]              nsets_q, nsets_d;
    logic [KW-1:0]           k_q, k_d;
    logic [8:0]              cyc_q, cyc_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    logic                    in_run;
    logic                    adv;
    logic                    last_set;
    logic [8:0]              row_off;

    assign in_run    = (state_q == S_RUN);
    // abort silences the array-facing strobes in the very cycle it is seen
    assign out_valid = in_run & (cyc_q > CYC_VALID) & ~abort;
    assign adv       = ~(out_valid & ~out_ready);
    assign alu_start = in_run & adv & ~abort;
    assign busy      = (state_q == S_PREFETCH) | in_run;
    assign done      = (state_q == S_DONE);
    assign sram_ren  = ~abort & ((state_q == S_PREFETCH) | (in_run & (k_q < K_MAX)));

    assign sram_raddr_w = addr_q;
    assign sram_raddr_d = addr_q;
    assign cycle_num    = cyc_q;

    assign row_off      = cyc_q - ROW0;
    assign matrix_index = out_valid ? 6'(row_off % ROWS) : 6'd0;
    assign last_set     = ({1'b0, set_q} + 7'd1) >= {1'b0, nsets_q};

    always_comb begin
        data_set = 6'd0;
        case (state_q)
            S_PREFETCH, S_RUN: data_set = set_q;
            // out-of-range set index keeps the array from emitting results
            S_DONE:            data_set = nsets_q;
            default:           data_set = 6'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        nsets_d = nsets_q;
        k_d     = k_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        if (abort) begin
            state_d = S_IDLE;
            set_d   = 6'd0;
            k_d     = '0;
            cyc_d   = 9'd0;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nsets_d = num_sets;
                        set_d   = 6'd0;
                        k_d     = '0;
                        cyc_d   = 9'd0;
                        addr_d  = '0;
                        state_d = (num_sets != 6'd0) ? S_PREFETCH : S_DONE;
                    end
                end
                S_PREFETCH: begin
                    state_d = S_RUN;
                    k_d     = K_ONE;
                    cyc_d   = 9'd0;
                    if (K_ONE < K_MAX) addr_d = addr_q + ADDR_ONE;
                end
                S_RUN: begin
                    if (adv) begin
                        cyc_d = cyc_q + 9'd1;
                        if (k_q < K_MAX) k_d = k_q + K_ONE;
                        if (k_q < K_MAX - K_ONE) addr_d = addr_q + ADDR_ONE;
                        if (cyc_q == CYC_LAST) begin
                            cyc_d = 9'd0;
                            k_d   = '0;
                            if (!last_set) begin
                                // last word of a set is set*K+K-1, so +1 lands on the next base
                                set_d   = set_q + 6'd1;
                                addr_d  = addr_q + ADDR_ONE;
                                state_d = S_PREFETCH;
                            end else begin
                                addr_d  = '0;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= S_IDLE;
            set_q   <= 6'd0;
            nsets_q <= 6'd0;
            k_q     <= '0;
            cyc_q   <= 9'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            nsets_q <= nsets_d;
            k_q     <= k_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            perf_q <= 16'd0;
        end else if ((state_q == S_IDLE) && start && !abort) begin
            perf_q <= 16'd0;
        end else if (in_run && !adv && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl; a second instance with ADDR_WIDTH=4 covers address wrap.
module tb_systolic_ctrl;

    logic       clk = 1'b0;
    logic       srstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic [5:0] num_sets = 6'd0;

    logic       busy, done, sram_ren, alu_start, out_valid;
    logic [9:0] sram_raddr_w, sram_raddr_d;
    logic [8:0] cycle_num;
    logic [5:0] data_set, matrix_index;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] perf_stall_cnt, perf4;
`endif

    logic       busy4, done4, ren4, alu4, ov4;
    logic [3:0] aw4, ad4;
    logic [8:0] cyc4;
    logic [5:0] ds4, mi4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_ctrl u_dut (
        .clk(clk), .srstn(srstn), .start(start), .num_sets(num_sets), .abort(abort),
        .out_ready(out_ready), .busy(busy), .done(done), .sram_ren(sram_ren),
        .sram_raddr_w(sram_raddr_w), .sram_raddr_d(sram_raddr_d), .alu_start(alu_start),
        .cycle_num(cycle_num), .data_set(data_set), .matrix_index(matrix_index),
        .out_valid(out_valid)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    systolic_ctrl #(.ADDR_WIDTH(4)) u_dut4 (
        .clk(clk), .srstn(srstn), .start(start), .num_sets(num_sets), .abort(abort),
        .out_ready(out_ready), .busy(busy4), .done(done4), .sram_ren(ren4),
        .sram_raddr_w(aw4), .sram_raddr_d(ad4), .alu_start(alu4),
        .cycle_num(cyc4), .data_set(ds4), .matrix_index(mi4), .out_valid(ov4)
`ifdef SYSTOLIC_CTRL_PERF_EN
        , .perf_stall_cnt(perf4)
`endif
    );

    function automatic logic [45:0] obs();
        return {busy, done, sram_ren, alu_start, out_valid, cycle_num, matrix_index,
                data_set, sram_raddr_w, sram_raddr_d};
    endfunction

    function automatic logic [45:0] ev(input logic bz, input logic dn, input logic rn,
                                       input logic al, input logic ov, input int cy,
                                       input int mi, input int ds, input int ad);
        logic [9:0] a;
        a = 10'(ad);
        return {bz, dn, rn, al, ov, 9'(cy), 6'(mi), 6'(ds), a, a};
    endfunction

    // Unstalled RUN cycle c of set s at K=8, ARRAY_SIZE=8
    function automatic logic [45:0] run_exp(input int s, input int c);
        return ev(1'b1, 1'b0, c < 7, 1'b1, c > 8, c, (c > 8) ? c - 9 : 0, s,
                  s * 8 + ((c < 7) ? c + 1 : 7));
    endfunction

    function automatic logic [45:0] pf_exp(input int s);
        return ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, s, s * 8);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [45:0] g;
        srstn = 1'b0;
        repeat (2) step();
        #1;
        g = obs();
        checks++;
        if (g !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", g);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (perf_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf got=%0d exp=0", perf_stall_cnt);
        end
`endif
        step();
        srstn = 1'b1;
        step();
        #1;
        g = obs();
        checks++;
        if (g !== 46'd0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h exp=0", g);
        end
    endtask

    task automatic test_single();
        logic [45:0] g, e;
        step();
        start = 1'b1; num_sets = 6'd1;
        step();
        start = 1'b0;
        #1;
        g = obs(); e = pf_exp(0);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL single_prefetch got=%h exp=%h", g, e);
        end
        for (int c = 0; c < 17; c++) begin
            step();
            #1;
            g = obs(); e = run_exp(0, c);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL single_run c=%0d got=%h exp=%h", c, g, e);
            end
        end
        step();
        #1;
        checks++;
        if ({busy, done, sram_ren, alu_start, out_valid, data_set} !== {5'b01000, 6'd1}) begin
            errors++;
            $display("FAIL single_done got=%b exp=%b",
                     {busy, done, sram_ren, alu_start, out_valid, data_set}, {5'b01000, 6'd1});
        end
        step();
        #1;
        checks++;
        if ({busy, done, sram_ren, alu_start} !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle got=%b exp=0000", {busy, done, sram_ren, alu_start});
        end
    endtask

    task automatic test_multi();
        logic [45:0] g, e;
        int nov;
        nov = 0;
        step();
        start = 1'b1; num_sets = 6'd3;
        step();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            g = obs(); e = pf_exp(s);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL multi_prefetch s=%0d got=%h exp=%h", s, g, e);
            end
            for (int c = 0; c < 17; c++) begin
                step();
                #1;
                g = obs(); e = run_exp(s, c);
                nov += int'(out_valid);
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL multi_run s=%0d c=%0d got=%h exp=%h", s, c, g, e);
                end
            end
            step();
        end
        #1;
        checks++;
        if ({busy, done, sram_ren, alu_start, out_valid, data_set} !== {5'b01000, 6'd3}) begin
            errors++;
            $display("FAIL multi_done got=%b exp=%b",
                     {busy, done, sram_ren, alu_start, out_valid, data_set}, {5'b01000, 6'd3});
        end
        checks++;
        if (nov != 24) begin
            errors++;
            $display("FAIL multi_valid_count got=%0d exp=24", nov);
        end
        step();
    endtask

    task automatic test_stall();
        logic [45:0] g, e;
        step();
        start = 1'b1; num_sets = 6'd1;
        step();
        start = 1'b0;
        for (int c = 0; c < 17; c++) begin
            step();
            #1;
            if (c == 11) begin
                for (int st = 0; st < 4; st++) begin
                    out_ready = 1'b0;
                    #1;
                    g = obs(); e = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11, 2, 0, 7);
                    checks++;
                    if (g !== e) begin
                        errors++;
                        $display("FAIL stall_hold st=%0d got=%h exp=%h", st, g, e);
                    end
                    step();
                end
                out_ready = 1'b1;
                #1;
            end
            g = obs(); e = run_exp(0, c);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stall_run c=%0d got=%h exp=%h", c, g, e);
            end
        end
        step();
        #1;
        checks++;
        if ({busy, done, data_set} !== {2'b01, 6'd1}) begin
            errors++;
            $display("FAIL stall_done got=%b exp=%b", {busy, done, data_set}, {2'b01, 6'd1});
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (perf_stall_cnt !== 16'd4) begin
            errors++;
            $display("FAIL stall_perf got=%0d exp=4", perf_stall_cnt);
        end
`endif
        step();
    endtask

    task automatic test_abort();
        logic [45:0] g, e;
        step();
        start = 1'b1; num_sets = 6'd2;
        step();
        start = 1'b0;
        for (int c = 0; c < 17; c++) step();
        step();
        #1;
        g = obs(); e = pf_exp(1);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL abort_prefetch1 got=%h exp=%h", g, e);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            #1;
            g = obs(); e = run_exp(1, c);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL abort_run1 c=%0d got=%h exp=%h", c, g, e);
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        checks++;
        if ({busy, done, sram_ren, alu_start, out_valid, cycle_num} !== 14'd0) begin
            errors++;
            $display("FAIL abort_idle got=%b exp=0",
                     {busy, done, sram_ren, alu_start, out_valid, cycle_num});
        end
        step();
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL abort_no_done got=%b exp=00", {busy, done});
        end
        start = 1'b1; abort = 1'b1; num_sets = 6'd1;
        step();
        start = 1'b0; abort = 1'b0;
        #1;
        checks++;
        if ({busy, done, sram_ren} !== 3'b000) begin
            errors++;
            $display("FAIL abort_beats_start got=%b exp=000", {busy, done, sram_ren});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        g = obs(); e = pf_exp(0);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL abort_restart_pf got=%h exp=%h", g, e);
        end
        step();
        #1;
        g = obs(); e = run_exp(0, 0);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL abort_restart_run got=%h exp=%h", g, e);
        end
        for (int c = 1; c < 17; c++) step();
        step();
        #1;
        checks++;
        if ({busy, done, data_set} !== {2'b01, 6'd1}) begin
            errors++;
            $display("FAIL abort_restart_done got=%b exp=%b", {busy, done, data_set}, {2'b01, 6'd1});
        end
        step();
    endtask

    task automatic test_zero_and_ignore();
        logic [45:0] g, e;
        step();
        start = 1'b1; num_sets = 6'd0;
        step();
        start = 1'b0;
        #1;
        checks++;
        if ({busy, done, sram_ren, alu_start, out_valid, data_set} !== {5'b01000, 6'd0}) begin
            errors++;
            $display("FAIL zero_done got=%b exp=%b",
                     {busy, done, sram_ren, alu_start, out_valid, data_set}, {5'b01000, 6'd0});
        end
        step();
        #1;
        checks++;
        if ({busy, done, sram_ren, alu_start} !== 4'b0000) begin
            errors++;
            $display("FAIL zero_idle got=%b exp=0000", {busy, done, sram_ren, alu_start});
        end
        start = 1'b1; num_sets = 6'd1;
        step();
        start = 1'b0;
        #1;
        g = obs(); e = pf_exp(0);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL ignore_prefetch got=%h exp=%h", g, e);
        end
        for (int c = 0; c < 17; c++) begin
            step();
            if (c == 4) begin
                start = 1'b1; num_sets = 6'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            g = obs(); e = run_exp(0, c);
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL ignore_run c=%0d got=%h exp=%h", c, g, e);
            end
        end
        step();
        start = 1'b0;
        #1;
        checks++;
        if ({busy, done, data_set} !== {2'b01, 6'd1}) begin
            errors++;
            $display("FAIL ignore_done got=%b exp=%b", {busy, done, data_set}, {2'b01, 6'd1});
        end
        step();
    endtask

    task automatic test_reset_and_wrap();
        logic [45:0] g;
        logic [7:0]  ga, ea;
        step();
        start = 1'b1; num_sets = 6'd1;
        step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) step();
        srstn = 1'b0;
        step();
        #1;
        g = obs();
        checks++;
        if (g !== 46'd0) begin
            errors++;
            $display("FAIL midrun_reset got=%h exp=0", g);
        end
        srstn = 1'b1;
        step();
        start = 1'b1; num_sets = 6'd3;
        step();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            ga = {aw4, ad4}; ea = {2{4'((s * 8) % 16)}};
            checks++;
            if (ga !== ea) begin
                errors++;
                $display("FAIL wrap_prefetch s=%0d got=%h exp=%h", s, ga, ea);
            end
            for (int c = 0; c < 17; c++) begin
                step();
                #1;
                ga = {aw4, ad4}; ea = {2{4'((s * 8 + ((c < 7) ? c + 1 : 7)) % 16)}};
                checks++;
                if (ga !== ea) begin
                    errors++;
                    $display("FAIL wrap_run s=%0d c=%0d got=%h exp=%h", s, c, ga, ea);
                end
            end
            step();
        end
        #1;
        checks++;
        if ({done4, ds4} !== {1'b1, 6'd3}) begin
            errors++;
            $display("FAIL wrap_done got=%b exp=%b", {done4, ds4}, {1'b1, 6'd3});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_abort();
        test_zero_and_ignore();
        test_reset_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the 8x8 systolic MVM array. On a start pulse it runs `num_sets` consecutive data sets through the array. For each set it:
- issues weight/data SRAM read addresses,
- drives `alu_start`, `cycle_num`, `data_set` and `matrix_index` into the array,
- flags the cycles where the array's `mul_outcome` bus carries a valid result row.

It also supports downstream back-pressure and abort, and sits between the top-level command interface and the systolic array/SRAM pair.

Parameters:
- ARRAY_SIZE, 8, array rows/cols; output rows per set.
- K_ACCUM_DEPTH, 8, accumulation depth; SRAM words read per set.
- ADDR_WIDTH, 10, SRAM read address width.
- RUN_LEN (localparam), K_ACCUM_DEPTH+ARRAY_SIZE+1, compute cycles per set (17 at defaults).

Ports:
- clk  in  1  clock.
- srstn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle command pulse; ignored unless idle.
- num_sets  in  6  sets to process; sampled on accepted start.
- abort  in  1  return to IDLE immediately.
- out_ready  in  1  downstream can accept a result row.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse after the last set completes.
- sram_ren  out  1  SRAM read enable (both SRAMs).
- sram_raddr_w  out  ADDR_WIDTH  weight SRAM address.
- sram_raddr_d  out  ADDR_WIDTH  data SRAM address.
- alu_start  out  1  array advance enable.
- cycle_num  out  9  per-set compute cycle index.
- data_set  out  6  current set index.
- matrix_index  out  6  row index of current result.
- out_valid  out  1  `mul_outcome` row valid this cycle.

Behaviour:
Reset values (`srstn`=0 at posedge):
- State IDLE.
- All outputs 0, except `data_set` = 0.
- Internal k counter and set counter 0.

States: IDLE, PREFETCH, RUN, DONE.

IDLE:
- `busy`=0, `alu_start`=0.
- `start`=1 with `num_sets`>0: latch `num_sets`, set=0, go PREFETCH.
- `start`=1 with `num_sets`=0: go DONE (`done` pulse, no reads).

PREFETCH (exactly 1 cycle, absorbs 1-cycle SRAM read latency):
- `sram_ren`=1, both addresses = set*K_ACCUM_DEPTH, k=1, `cycle_num`=0. Next state RUN.

RUN, advance condition adv = ~(`out_valid` & ~`out_ready`):
- When adv: `alu_start`=1 and `cycle_num` increments.
- While k<K_ACCUM_DEPTH: `sram_ren`=1, addresses = set*K_ACCUM_DEPTH+k, k increments on adv. After that `sram_ren`=0 and addresses hold.
- When `cycle_num`=RUN_LEN-1 and adv:
  - if set+1 < `num_sets`: set++, go PREFETCH;
  - else go DONE.

Stall (adv=0):
- `alu_start`=0.
- `cycle_num`, k, addresses and `sram_ren` held, so the SRAM re-presents the same word.
- Array state is frozen.

`out_valid` = RUN & (`cycle_num` > K_ACCUM_DEPTH).

`matrix_index` = (`cycle_num`-K_ACCUM_DEPTH-1) mod ARRAY_SIZE when `out_valid`, else 0.

Combinational from state/counters:
- `busy`, `alu_start`, `out_valid`, `matrix_index`.

DONE (1 cycle):
- `done`=1, `busy`=0.
- `data_set` = latched `num_sets`, which suppresses array output.
- Next state IDLE.

`data_set` = set in PREFETCH/RUN.

Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.

`abort` (any state):
- Next cycle IDLE; `done` not pulsed.
- Counters cleared; `alu_start`, `sram_ren`, `out_valid` low from that cycle on.
- `abort` dominates `start` in the same cycle.

`start` while busy: ignored, with no effect on counters.

Optional Feature:
SYSTOLIC_CTRL_PERF_EN.

Defined:
- Adds output port `perf_stall_cnt` [15:0], reset 0.
- Cleared on accepted start.
- Increments each RUN cycle with adv=0; saturates at 16'hFFFF.

Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. `start`, `num_sets`=1, `out_ready`=1 -> PREFETCH 1 cycle, then addresses 0..7 with `sram_ren` for 8 cycles; `out_valid` on `cycle_num` 9..16, `matrix_index` 0..7; `done` 19 cycles after start; `busy` low with `done`.
2. `num_sets`=3 -> three RUN phases separated by one PREFETCH each; addresses 0-7, 8-15, 16-23; `data_set` 0,1,2 then 3 in DONE; exactly 24 `out_valid` cycles.
3. `out_ready`=0 for 4 cycles at `cycle_num`=11 -> `cycle_num` holds 11, `alu_start`=0 for 4 cycles, `matrix_index` stays 2; total latency +4; with SYSTOLIC_CTRL_PERF_EN, `perf_stall_cnt`=4.
4. `abort` at `cycle_num`=5 of set 1 -> next cycle IDLE, `busy`=0, no `done`; new `start`, `num_sets`=1 -> restarts at address 0.
5. `start` with `num_sets`=0 -> `done` next cycle, `sram_ren`/`alu_start` never asserted; `start` pulsed mid-RUN -> ignored, sequence unchanged.
6. `srstn` low mid-RUN -> next posedge all outputs 0, IDLE; ADDR_WIDTH=4, `num_sets`=3 -> set 2 addresses wrap 0..7.
